// File: rtl/periph_pkg.sv
// -----------------------------------------------------------------------------
// periph_pkg
//   Shared types and helpers for the peripheral operand loader slice.
//   - oploader_state_t : loader FSM state (COLLECT while filling, FULL while
//                        the set waits for the consumer)
//   - clog2_min1       : $clog2 clamped to at least 1, so that index ports never
//                        collapse to zero width when a count is 1
// -----------------------------------------------------------------------------
package periph_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } oploader_state_t;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/peripheral_edge_pulse.sv
// -----------------------------------------------------------------------------
// peripheral_edge_pulse
//   Brings an asynchronous button level into the clk domain and turns each
//   rising edge into a single-cycle pulse. A press held for any length gives
//   exactly one pulse.
//   Latency: with din first sampled high at posedge P0, pulse is high for the
//   cycle that follows posedge P2.
// Ports
//   clk    in  system clock
//   reset  in  synchronous, active-high reset (clears all flops)
//   din    in  button level, asynchronous to clk
//   pulse  out registered 1-cycle pulse per rising edge of din
// -----------------------------------------------------------------------------
module peripheral_edge_pulse (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic pulse
);

    logic sync1;
    logic sync2;
    logic sync2_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync2_d <= 1'b0;
            pulse   <= 1'b0;
        end else begin
            sync1   <= din;
            sync2   <= sync1;
            sync2_d <= sync2;
            // Registered so the pulse has no combinational path from din.
            pulse   <= sync2 & ~sync2_d;
        end
    end

endmodule

// File: rtl/peripheral_operand_loader.sv
// -----------------------------------------------------------------------------
// peripheral_operand_loader
//   Collects NUM_OPS operands of DATA_W bits from a switch bus, one IN_W-bit
//   chunk per enter press, and hands the complete set to the datapath with a
//   valid/ready handshake.
// Parameters
//   DATA_W     operand width (multiple of IN_W)
//   IN_W       chunk / switch width
//   NUM_OPS    number of operands (>=1), operand 0 = A, 1 = B, ...
//   MSB_FIRST  0: first chunk entered is least significant; 1: most significant
// Ports
//   clk, reset  clock, synchronous active-high reset
//   inputdata   switch value, captured on a detected enter press
//   enterpulse  enter button level (asynchronous)
//   clear       synchronous abort, zeroes the set and counters
//   ops_o       operand i at [i*DATA_W +: DATA_W]
//   op_sel      operand currently being filled
//   chunk_sel   next chunk to be filled, in entry order
//   busy        COLLECT with at least one chunk already loaded
//   ops_valid   full set available
//   ops_ready   consumer accepts the set
// -----------------------------------------------------------------------------
module peripheral_operand_loader
    import periph_pkg::*;
#(
    parameter  int DATA_W    = 32,
    parameter  int IN_W      = 8,
    parameter  int NUM_OPS   = 2,
    parameter  int MSB_FIRST = 0,
    localparam int CHUNKS    = DATA_W / IN_W,
    localparam int OPW       = clog2_min1(NUM_OPS),
    localparam int CHW       = clog2_min1(CHUNKS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [IN_W-1:0]           inputdata,
    input  logic                      enterpulse,
    input  logic                      clear,
    output logic [NUM_OPS*DATA_W-1:0] ops_o,
    output logic [OPW-1:0]            op_sel,
    output logic [CHW-1:0]            chunk_sel,
    output logic                      busy,
    output logic                      ops_valid,
    input  logic                      ops_ready
);

    if ((DATA_W % IN_W) != 0 || NUM_OPS < 1) begin : g_param_check
        $error("peripheral_operand_loader: DATA_W must be a multiple of IN_W and NUM_OPS >= 1");
    end

    oploader_state_t state;
    oploader_state_t state_d;

    logic            ent;
    logic            last_chunk;
    logic            last_op;
    logic            do_write;
    logic            do_accept;
    logic [OPW-1:0]  op_sel_d;
    logic [CHW-1:0]  chunk_sel_d;
    logic [CHW-1:0]  slot;
    logic            busy_d;
    logic            valid_d;

    logic [NUM_OPS-1:0][CHUNKS-1:0][IN_W-1:0] ops_q;

    peripheral_edge_pulse u_enter (
        .clk   (clk),
        .reset (reset),
        .din   (enterpulse),
        .pulse (ent)
    );

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= COLLECT;
            op_sel    <= '0;
            chunk_sel <= '0;
            busy      <= 1'b0;
            ops_valid <= 1'b0;
        end else begin
            state     <= state_d;
            op_sel    <= op_sel_d;
            chunk_sel <= chunk_sel_d;
            busy      <= busy_d;
            ops_valid <= valid_d;
        end
    end

    // ------------------------------------------------------- next state + counters
    // Priority below reset: clear, then accept, then a chunk write.
    always_comb begin
        last_chunk  = (chunk_sel == CHW'(CHUNKS - 1));
        last_op     = (op_sel == OPW'(NUM_OPS - 1));
        do_write    = (state == COLLECT) && ent && !clear;
        do_accept   = (state == FULL) && ops_ready && !clear;

        state_d     = state;
        op_sel_d    = op_sel;
        chunk_sel_d = chunk_sel;

        if (clear || do_accept) begin
            state_d     = COLLECT;
            op_sel_d    = '0;
            chunk_sel_d = '0;
        end else if (do_write) begin
            if (last_chunk) begin
                chunk_sel_d = '0;
                if (last_op) begin
                    op_sel_d = '0;
                    state_d  = FULL;
                end else begin
                    op_sel_d = op_sel + 1'b1;
                end
            end else begin
                chunk_sel_d = chunk_sel + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------- output decode
    // Outputs are decoded from next-state values and registered above, so
    // ops_valid rises on the same edge as the final chunk write.
    always_comb begin
        valid_d = (state_d == FULL);
        busy_d  = (state_d == COLLECT) && ((op_sel_d != '0) || (chunk_sel_d != '0));
    end

    // ---------------------------------------------------------------- datapath
    // Entry order maps onto a physical chunk slot; MSB_FIRST reverses it.
    assign slot = (MSB_FIRST != 0) ? (CHW'(CHUNKS - 1) - chunk_sel) : chunk_sel;

    for (genvar o = 0; o < NUM_OPS; o++) begin : g_op
        for (genvar c = 0; c < CHUNKS; c++) begin : g_chunk
            logic [IN_W-1:0] q;

            always_ff @(posedge clk) begin
                if (reset || clear) begin
                    q <= '0;
                end else if (do_write && (op_sel == OPW'(o)) && (slot == CHW'(c))) begin
                    q <= inputdata;
                end
            end

            assign ops_q[o][c] = q;
        end
    end

    assign ops_o = ops_q;

endmodule
